// File: rtl/rf_wport_arb.sv
// rf_wport_arb: write-port controller for a 32x32 register file.
//
// Arbitrates the single RF write port between three sources, highest priority first:
//   1. core writeback (wb_*), passed straight through whenever wb_we=1
//   2. the internal clear sequencer (state CLEAR)
//   3. a debug write requester (dbg_*), served only in IDLE
// The clear sequencer writes 0 to x1..x31, except that x2 gets SP_INIT and x3 gets GP_INIT.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   wb_we/wb_wa/wb_wd    core writeback request
//   dbg_req/dbg_wa/dbg_wd debug write request (held until acked)
//   dbg_ack              combinational grant; RF write lands on the next clk edge
//   clr_start            starts a clear (sampled in IDLE only)
//   busy                 clear in progress (CLEAR or DONE), registered
//   clr_done             one-cycle pulse in the cycle after the final clear write
//   rf_we/rf_wa/rf_wd    RF write port
module rf_wport_arb #(
    parameter int unsigned         XLEN    = 32,
    parameter logic [XLEN-1:0]     SP_INIT = 32'h2ffc,
    parameter logic [XLEN-1:0]     GP_INIT = 32'h1800
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            wb_we,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_wd,

    input  logic            dbg_req,
    input  logic [4:0]      dbg_wa,
    input  logic [XLEN-1:0] dbg_wd,
    output logic            dbg_ack,

    input  logic            clr_start,
    output logic            busy,
    output logic            clr_done,

    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       busy_q;
    logic       done_q;

    logic [XLEN-1:0] clr_wd;

    // Next-state logic. A writeback in CLEAR stalls the counter so the suppressed
    // clear write is retried on the next free cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start) begin
                    state_d = StClear;
                    cnt_d   = 5'd1;
                end
            end
            StClear: begin
                if (!wb_we) begin
                    if (cnt_q == 5'd31) begin
                        state_d = StDone;
                        cnt_d   = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Status flags are registered decodes of the next state so they track state_q.
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
        end
    end

    assign busy     = busy_q;
    assign clr_done = done_q;

    always_comb begin
        unique case (cnt_q)
            5'd2:    clr_wd = SP_INIT;
            5'd3:    clr_wd = GP_INIT;
            default: clr_wd = '0;
        endcase
    end

    // Write-port mux; wb wins unconditionally, including wa=0 which the RF discards.
    always_comb begin
        rf_we   = 1'b0;
        rf_wa   = 5'd0;
        rf_wd   = '0;
        dbg_ack = 1'b0;
        if (wb_we) begin
            rf_we = 1'b1;
            rf_wa = wb_wa;
            rf_wd = wb_wd;
        end else if (state_q == StClear) begin
            rf_we = 1'b1;
            rf_wa = cnt_q;
            rf_wd = clr_wd;
        end else if ((state_q == StIdle) && dbg_req) begin
            dbg_ack = 1'b1;
            rf_we   = 1'b1;
            rf_wa   = dbg_wa;
            rf_wd   = dbg_wd;
        end
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed self-checking bench for rf_wport_arb. Inputs change at the falling edge and
// outputs are checked 1 time unit later; a small register-file model captures rf_* writes.
module tb_rf_wport_arb;

    logic        clk;
    logic        rstn;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        dbg_req;
    logic [4:0]  dbg_wa;
    logic [31:0] dbg_wd;
    logic        dbg_ack;
    logic        clr_start;
    logic        busy;
    logic        clr_done;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt;

    logic [31:0] rf [32];

    rf_wport_arb #(
        .XLEN    (32),
        .SP_INIT (32'h2ffc),
        .GP_INIT (32'h1800)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wb_we     (wb_we),
        .wb_wa     (wb_wa),
        .wb_wd     (wb_wd),
        .dbg_req   (dbg_req),
        .dbg_wa    (dbg_wa),
        .dbg_wd    (dbg_wd),
        .dbg_ack   (dbg_ack),
        .clr_start (clr_start),
        .busy      (busy),
        .clr_done  (clr_done),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model; x0 is hardwired to zero.
    always @(posedge clk) begin
        if (rf_we && (rf_wa != 5'd0)) rf[rf_wa] <= rf_wd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] clr_val(input int k);
        if (k == 2) return 32'h2ffc;
        if (k == 3) return 32'h1800;
        return 32'h0;
    endfunction

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rstn = 1'b0; wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        dbg_req = 1'b0; dbg_wa = '0; dbg_wd = '0; clr_start = 1'b0;

        // Reset state
        nxt(); settle();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, clr_done}, 32'd0);
        chk("rst_we", {31'd0, rf_we}, 32'd0);
        chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
        nxt(); rstn = 1'b1;

        // Debug write blocked by wb, then granted once wb drops
        nxt(); dbg_req = 1'b1; dbg_wa = 5'd7; dbg_wd = 32'h1234;
        wb_we = 1'b1; wb_wa = 5'd9; wb_wd = 32'h55; settle();
        chk("dbg_blk_ack", {31'd0, dbg_ack}, 32'd0);
        chk("dbg_blk_wa", {27'd0, rf_wa}, 32'd9);
        chk("dbg_blk_wd", rf_wd, 32'h55);
        nxt(); wb_we = 1'b0; settle();
        chk("dbg_ack", {31'd0, dbg_ack}, 32'd1);
        chk("dbg_we", {31'd0, rf_we}, 32'd1);
        chk("dbg_wa", {27'd0, rf_wa}, 32'd7);
        chk("dbg_wd", rf_wd, 32'h1234);
        nxt(); dbg_req = 1'b0; settle();
        chk("x7_dbg", rf[7], 32'h1234);
        chk("x9_wb", rf[9], 32'h55);
        chk("idle_we", {31'd0, rf_we}, 32'd0);

        // Clear with no interference: clr_start at cycle 0
        nxt(); clr_start = 1'b1;
        nxt(); clr_start = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            if (k > 1) nxt();
            settle();
            chk("clr_we", {31'd0, rf_we}, 32'd1);
            chk("clr_wa", {27'd0, rf_wa}, k);
            chk("clr_wd", rf_wd, clr_val(k));
            chk("clr_busy", {31'd0, busy}, 32'd1);
            chk("clr_nodone", {31'd0, clr_done}, 32'd0);
        end
        nxt(); settle();
        chk("c32_done", {31'd0, clr_done}, 32'd1);
        chk("c32_busy", {31'd0, busy}, 32'd1);
        chk("c32_we", {31'd0, rf_we}, 32'd0);
        nxt(); settle();
        chk("c33_busy", {31'd0, busy}, 32'd0);
        chk("c33_done", {31'd0, clr_done}, 32'd0);
        chk("x2_sp", rf[2], 32'h2ffc);
        chk("x3_gp", rf[3], 32'h1800);
        chk("x7_clr", rf[7], 32'h0);
        chk("x9_clr", rf[9], 32'h0);

        // wb preemption at cnt=10 for 3 cycles
        clr_start = 1'b1;
        nxt(); clr_start = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            if (c > 1) nxt();
            if (c >= 10 && c <= 12) begin
                wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'hdead;
            end else begin
                wb_we = 1'b0;
            end
            settle();
            if (c >= 10 && c <= 12) begin
                chk("pre_wb_wa", {27'd0, rf_wa}, 32'd5);
                chk("pre_wb_wd", rf_wd, 32'hdead);
            end else if (c < 10) begin
                chk("pre_wa_lo", {27'd0, rf_wa}, c);
            end else if (c <= 34) begin
                chk("pre_wa_hi", {27'd0, rf_wa}, c - 3);
            end
            if (c == 13) chk("pre_wd_cnt10", rf_wd, 32'h0);
            chk("pre_done", {31'd0, clr_done}, (c == 35) ? 32'd1 : 32'd0);
        end
        nxt(); settle();
        chk("pre_busy_off", {31'd0, busy}, 32'd0);
        chk("x5_wb_wins", rf[5], 32'hdead);

        // Debug request raised at cycle 5 of a clear waits until IDLE
        clr_start = 1'b1;
        nxt(); clr_start = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            if (c > 1) nxt();
            if (c == 5) begin
                dbg_req = 1'b1; dbg_wa = 5'd4; dbg_wd = 32'habcd;
            end
            settle();
            if (c >= 5 && c <= 32) chk("dclr_noack", {31'd0, dbg_ack}, 32'd0);
            if (c >= 5 && c <= 31) chk("dclr_wa", {27'd0, rf_wa}, c);
            if (c == 32) chk("dclr_done", {31'd0, clr_done}, 32'd1);
            if (c == 33) begin
                chk("dclr_ack", {31'd0, dbg_ack}, 32'd1);
                chk("dclr_ack_wa", {27'd0, rf_wa}, 32'd4);
            end
        end
        nxt(); dbg_req = 1'b0; settle();
        chk("x4_dbg_final", rf[4], 32'habcd);

        // Preload x20, then reset at cnt=20
        dbg_req = 1'b1; dbg_wa = 5'd20; dbg_wd = 32'h7777;
        nxt(); dbg_req = 1'b0; clr_start = 1'b1;
        nxt(); clr_start = 1'b0;
        for (int c = 2; c <= 20; c++) nxt();
        settle();
        chk("pre_rst_wa", {27'd0, rf_wa}, 32'd20);
        rstn = 1'b0; settle();
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, clr_done}, 32'd0);
        chk("mrst_we", {31'd0, rf_we}, 32'd0);
        nxt(); rstn = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            nxt(); settle();
            if (clr_done) done_cnt++;
            chk("mrst_idle_busy", {31'd0, busy}, 32'd0);
        end
        chk("mrst_no_done", done_cnt, 32'd0);
        chk("x19_kept", rf[19], 32'h0);
        chk("x20_unwritten", rf[20], 32'h7777);

        // clr_start held high across a whole clear: runs once, then restarts
        clr_start = 1'b1;
        done_cnt = 0;
        for (int c = 1; c <= 34; c++) begin
            nxt(); settle();
            if (clr_done) done_cnt++;
            if (c <= 31) chk("rep_wa", {27'd0, rf_wa}, c);
            if (c == 33) begin
                chk("rep_idle_busy", {31'd0, busy}, 32'd0);
                chk("rep_idle_we", {31'd0, rf_we}, 32'd0);
            end
            if (c == 34) begin
                chk("rep_restart_wa", {27'd0, rf_wa}, 32'd1);
                chk("rep_restart_busy", {31'd0, busy}, 32'd1);
            end
        end
        chk("rep_one_done", done_cnt, 32'd1);
        clr_start = 1'b0;
        chk("x20_cleared", rf[20], 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
